// File: rtl/divider_taint_track_bitwise_if.sv
// Start/done handshake and operand/result bus of the taint-tracked divider.
// Every data and control signal has a shadow *_t taint vector.
interface divider_taint_track_bitwise_if #(
  parameter int WIDTH = 256
);
  logic             start;
  logic             start_t;
  logic [WIDTH-1:0] dividend;
  logic [WIDTH-1:0] dividend_t;
  logic [WIDTH-1:0] divisor;
  logic [WIDTH-1:0] divisor_t;
  logic [WIDTH-1:0] quotient;
  logic [WIDTH-1:0] quotient_t;
  logic [WIDTH-1:0] remainder;
  logic [WIDTH-1:0] remainder_t;
  logic             quotientDone;
  logic             quotientDone_t;

  // Requester side: issues operands, consumes results
  modport master (
    output start, start_t, dividend, dividend_t, divisor, divisor_t,
    input  quotient, quotient_t, remainder, remainder_t, quotientDone, quotientDone_t
  );

  // Divider side
  modport slave (
    input  start, start_t, dividend, dividend_t, divisor, divisor_t,
    output quotient, quotient_t, remainder, remainder_t, quotientDone, quotientDone_t
  );
endinterface

// File: rtl/divider_taint_track_bitwise.sv
// Constant-time restoring divider with bitwise conservative taint tracking.
// One quotient bit per ITER cycle, always WIDTH iterations; the trial
// subtraction is computed every cycle and the result is muxed, so timing
// never depends on operand values. Divide by zero falls out naturally as
// quotient = all ones, remainder = dividend.
module divider_taint_track_bitwise #(
  parameter int WIDTH = 256
) (
  input  logic clk,
  input  logic rst,
  divider_taint_track_bitwise_if.slave bus
);

  localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_LOAD = 2'd1,
    S_ITER = 2'd2,
    S_DONE = 2'd3
  } state_t;

  state_t             r_state;
  logic               r_state_t;
  logic [CNT_W-1:0]   r_cnt;

  // Working registers: partial remainder (one guard bit), quotient/dividend
  // shift register, divisor, and their taint shadows.
  logic [WIDTH:0]     r_rem;
  logic [WIDTH-1:0]   r_quo;
  logic [WIDTH-1:0]   r_div;
  logic [WIDTH:0]     r_rem_t;
  logic [WIDTH-1:0]   r_quo_t;
  logic [WIDTH-1:0]   r_div_t;

  // Result registers
  logic [WIDTH-1:0]   r_quotient;
  logic [WIDTH-1:0]   r_quotient_t;
  logic [WIDTH-1:0]   r_remainder;
  logic [WIDTH-1:0]   r_remainder_t;
  logic               r_done;
  logic               r_done_t;

  // One iteration step. The shifted remainder and the difference carry an
  // extra top bit so the borrow appears as the sign of w_diff.
  logic [WIDTH+1:0]   w_r_sh;
  logic [WIDTH+1:0]   w_diff;
  logic               w_ge;
  logic [WIDTH:0]     w_r_next;
  logic [WIDTH-1:0]   w_q_next;
  logic [WIDTH+1:0]   w_rt_sh;
  logic               w_c;
  logic [WIDTH:0]     w_rt_next;
  logic [WIDTH-1:0]   w_qt_next;

  assign w_r_sh    = {r_rem, r_quo[WIDTH-1]};
  assign w_diff    = w_r_sh - {2'b00, r_div};
  assign w_ge      = ~w_diff[WIDTH+1];
  assign w_r_next  = w_ge ? w_diff[WIDTH:0] : w_r_sh[WIDTH:0];
  assign w_q_next  = {r_quo[WIDTH-2:0], w_ge};

  // Taint follows its data bit through the shift; the compare outcome is
  // tainted if any shifted remainder bit or any divisor bit is tainted, and a
  // tainted compare taints the whole new remainder. A tainted control path
  // (r_state_t) taints everything written.
  assign w_rt_sh   = {r_rem_t, r_quo_t[WIDTH-1]};
  assign w_c       = (|w_rt_sh) | (|r_div_t);
  assign w_rt_next = (w_c | r_state_t) ? '1 : w_rt_sh[WIDTH:0];
  assign w_qt_next = r_state_t ? '1 : {r_quo_t[WIDTH-2:0], w_c};

  // Control FSM and datapath registers; results are captured on the edge
  // into DONE so they are valid alongside the quotientDone pulse.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state       <= S_IDLE;
      r_state_t     <= 1'b0;
      r_cnt         <= '0;
      r_rem         <= '0;
      r_quo         <= '0;
      r_div         <= '0;
      r_rem_t       <= '0;
      r_quo_t       <= '0;
      r_div_t       <= '0;
      r_quotient    <= '0;
      r_quotient_t  <= '0;
      r_remainder   <= '0;
      r_remainder_t <= '0;
      r_done        <= 1'b0;
      r_done_t      <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          r_state_t <= bus.start_t;
          if (bus.start) r_state <= S_LOAD;
        end
        S_LOAD: begin
          r_rem   <= '0;
          r_quo   <= bus.dividend;
          r_div   <= bus.divisor;
          r_rem_t <= {(WIDTH+1){r_state_t}};
          r_quo_t <= r_state_t ? '1 : bus.dividend_t;
          r_div_t <= r_state_t ? '1 : bus.divisor_t;
          r_cnt   <= CNT_W'(WIDTH - 1);
          r_state <= S_ITER;
        end
        S_ITER: begin
          r_rem   <= w_r_next;
          r_quo   <= w_q_next;
          r_rem_t <= w_rt_next;
          r_quo_t <= w_qt_next;
          r_cnt   <= r_cnt - CNT_W'(1);
          if (r_cnt == '0) begin
            r_quotient    <= w_q_next;
            r_remainder   <= w_r_next[WIDTH-1:0];
            r_quotient_t  <= w_qt_next;
            r_remainder_t <= w_rt_next[WIDTH-1:0];
            r_done        <= 1'b1;
            r_done_t      <= r_state_t;
            r_state       <= S_DONE;
          end
        end
        S_DONE: begin
          r_done   <= 1'b0;
          r_done_t <= 1'b0;
          r_state  <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign bus.quotient       = r_quotient;
  assign bus.quotient_t     = r_quotient_t;
  assign bus.remainder      = r_remainder;
  assign bus.remainder_t    = r_remainder_t;
  assign bus.quotientDone   = r_done;
  assign bus.quotientDone_t = r_done_t;

endmodule

// File: tb/tb_divider_taint_track_bitwise.sv
// Scoreboard bench for the taint-tracked divider at WIDTH=8: stimulus pushes
// hand-computed expectations, a negedge monitor pops one per quotientDone.
module tb_divider_taint_track_bitwise;

  localparam int W = 8;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int unsigned cyc = 0;

  int n_cmp = 0;
  int n_err = 0;

  typedef struct {
    int          id;
    int unsigned cyc;
    logic [W-1:0] q;
    logic [W-1:0] qt;
    logic [W-1:0] r;
    logic [W-1:0] rt;
    logic         dt;
  } exp_t;

  exp_t sb_q[$];

  divider_taint_track_bitwise_if #(.WIDTH(W)) bus ();

  divider_taint_track_bitwise #(.WIDTH(W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input int id, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s#%0d: got %0h required %0h", name, id, act, req);
    end
  endtask

  // Monitor: every quotientDone must match the oldest outstanding expectation
  always @(negedge clk) begin
    if (rst && bus.quotientDone === 1'b1) begin
      if (sb_q.size() == 0) begin
        n_cmp++;
        n_err++;
        $display("FAIL unexpected_done: got pulse at cycle %0d required none", cyc);
      end else begin
        exp_t e;
        e = sb_q.pop_front();
        check("latency",        e.id, cyc - e.cyc,        32'd10);
        check("quotient",       e.id, bus.quotient,       e.q);
        check("remainder",      e.id, bus.remainder,      e.r);
        check("quotient_t",     e.id, bus.quotient_t,     e.qt);
        check("remainder_t",    e.id, bus.remainder_t,    e.rt);
        check("quotientDone_t", e.id, bus.quotientDone_t, e.dt);
      end
    end
  end

  // Issue one division and queue its expected result; returns at the IDLE after DONE
  task automatic do_div(input int id,
                        input logic [W-1:0] dd, input logic [W-1:0] dv,
                        input logic [W-1:0] ddt, input logic [W-1:0] dvt, input logic st,
                        input logic [W-1:0] eq, input logic [W-1:0] eqt,
                        input logic [W-1:0] er, input logic [W-1:0] ert, input logic edt);
    exp_t e;
    @(posedge clk); #1;
    bus.dividend   = dd;
    bus.divisor    = dv;
    bus.dividend_t = ddt;
    bus.divisor_t  = dvt;
    bus.start_t    = st;
    bus.start      = 1'b1;
    e.id = id; e.cyc = cyc; e.q = eq; e.qt = eqt; e.r = er; e.rt = ert; e.dt = edt;
    sb_q.push_back(e);
    @(posedge clk); #1;
    bus.start   = 1'b0;
    bus.start_t = 1'b0;
    repeat (10) @(posedge clk);
  endtask

  initial begin
    bus.start      = 1'b0;
    bus.start_t    = 1'b0;
    bus.dividend   = '0;
    bus.divisor    = '0;
    bus.dividend_t = '0;
    bus.divisor_t  = '0;

    repeat (2) @(negedge clk);
    check("rst_quotient",       0, bus.quotient,       32'd0);
    check("rst_remainder",      0, bus.remainder,      32'd0);
    check("rst_taints",         0, {bus.quotient_t, bus.remainder_t}, 32'd0);
    check("rst_done",           0, {bus.quotientDone, bus.quotientDone_t}, 32'd0);
    @(posedge clk); #1;
    rst = 1'b1;

    // id, dividend, divisor, dividend_t, divisor_t, start_t, q, q_t, r, r_t, done_t
    do_div(1, 8'd100, 8'd7,   8'h00, 8'h00, 1'b0, 8'd14,  8'h00, 8'd2,  8'h00, 1'b0);
    do_div(2, 8'd255, 8'd1,   8'h00, 8'h00, 1'b0, 8'd255, 8'h00, 8'd0,  8'h00, 1'b0);
    do_div(3, 8'd0,   8'd255, 8'h00, 8'h00, 1'b0, 8'd0,   8'h00, 8'd0,  8'h00, 1'b0);
    do_div(4, 8'd55,  8'd0,   8'h00, 8'h00, 1'b0, 8'hFF,  8'h00, 8'd55, 8'h00, 1'b0);
    do_div(5, 8'd200, 8'd9,   8'h01, 8'h00, 1'b0, 8'd22,  8'h01, 8'd2,  8'hFF, 1'b0);
    do_div(6, 8'd200, 8'd9,   8'h00, 8'h80, 1'b0, 8'd22,  8'hFF, 8'd2,  8'hFF, 1'b0);
    do_div(7, 8'd200, 8'd9,   8'h00, 8'h80, 1'b1, 8'd22,  8'hFF, 8'd2,  8'hFF, 1'b1);
    do_div(8, 8'd17,  8'd5,   8'h00, 8'h00, 1'b1, 8'd3,   8'hFF, 8'd2,  8'hFF, 1'b1);
    do_div(9, 8'd100, 8'd7,   8'h00, 8'h00, 1'b0, 8'd14,  8'h00, 8'd2,  8'h00, 1'b0);

    // start held high and operands changed after LOAD: both ignored mid-operation
    begin
      exp_t e;
      @(posedge clk); #1;
      bus.dividend = 8'd77; bus.divisor = 8'd10; bus.start = 1'b1; bus.start_t = 1'b0;
      e.id = 10; e.cyc = cyc; e.q = 8'd7; e.qt = 8'h00; e.r = 8'd7; e.rt = 8'h00; e.dt = 1'b0;
      sb_q.push_back(e);
      repeat (2) @(posedge clk); #1;
      bus.dividend = 8'd250; bus.divisor = 8'd3; bus.dividend_t = 8'hFF; bus.start_t = 1'b1;
      repeat (3) @(posedge clk); #1;
      bus.start = 1'b0; bus.start_t = 1'b0; bus.dividend_t = 8'h00;
      repeat (8) @(posedge clk);
    end

    // reset asserted in cycle 5 of a division: no pulse, outputs cleared
    @(posedge clk); #1;
    bus.dividend = 8'd100; bus.divisor = 8'd7; bus.start = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    repeat (4) @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check("abort_quotient",  11, bus.quotient,  32'd0);
    check("abort_remainder", 11, bus.remainder, 32'd0);
    check("abort_done",      11, bus.quotientDone, 32'd0);
    @(posedge clk); #1;
    rst = 1'b1;
    repeat (12) @(posedge clk);

    do_div(12, 8'd100, 8'd7, 8'h00, 8'h00, 1'b0, 8'd14, 8'h00, 8'd2, 8'h00, 1'b0);

    repeat (3) @(posedge clk);
    check("pending", 99, sb_q.size(), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout required completion");
    $fatal(1, "watchdog expired");
  end

endmodule
